// File: rtl/xc20xx_cfg_pkg.sv
// Shared types and constants for the XC20xx serial configuration loader.
package xc20xx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_LENGTH,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [3:0]  PREAMBLE  = 4'b0010;
  localparam int unsigned STOP_BITS = 3;
  localparam int unsigned LEN_W     = 24;

  function automatic logic is_busy(input state_e s);
    return (s inside {ST_PREAMBLE, ST_LENGTH, ST_START, ST_DATA, ST_STOP});
  endfunction

endpackage

// File: rtl/xc20xx_cfg_shreg.sv
// Serial-in/parallel-out frame shift register; first bit shifted in ends at the MSB.
module xc20xx_cfg_shreg #(
  parameter int unsigned WIDTH = 71
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] par_o
);

  logic [WIDTH-1:0] par_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q <= '0;
    end else if (shift_en_i) begin
      par_q <= {par_q[WIDTH-2:0], ser_i};
    end
  end

  assign par_o = par_q;

endmodule

// File: rtl/xc20xx_cfg_loader.sv
// Bitstream loader: preamble/length header, then START/DATA/STOP framed configuration frames.
module xc20xx_cfg_loader
  import xc20xx_cfg_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 71,
  parameter int unsigned NUM_FRAMES = 160,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic                  K,
  input  logic                  R,
  input  logic                  DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic [ADDR_W-1:0]     FRAME_ADDR,
  output logic                  FRAME_WE,
  output logic [LEN_W-1:0]      LEN_CNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int unsigned CNT_MAX = (FRAME_BITS > LEN_W) ? FRAME_BITS : LEN_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [ADDR_W-1:0]     frame_cnt_q;
  logic                  pre_ok_q;
  logic [LEN_W-1:0]      len_q;
  logic [FRAME_BITS-1:0] fdata_q;
  logic [ADDR_W-1:0]     faddr_q;
  logic                  we_q, busy_q, done_q, err_q, rdy_q;
  logic                  take, pre_exp, last_stop;
  logic [1:0]            pidx;
  logic [FRAME_BITS-1:0] sh_par;

  xc20xx_cfg_shreg #(.WIDTH(FRAME_BITS)) u_shreg (
    .clk_i      (K),
    .rst_i      (R),
    .shift_en_i (take && (state_q == ST_DATA)),
    .ser_i      (DIN),
    .par_o      (sh_par)
  );

  always_comb begin
    take      = DIN_VALID && rdy_q;
    pidx      = 2'd3 - bit_cnt_q[1:0];
    pre_exp   = PREAMBLE[pidx];
    last_stop = (bit_cnt_q == CNT_W'(STOP_BITS - 1));
    state_d   = state_q;
    if (take) begin
      case (state_q)
        ST_IDLE:     if (!DIN) state_d = ST_PREAMBLE;
        // Mismatches are accumulated in pre_ok_q and judged once the 4th bit arrives.
        ST_PREAMBLE: if (bit_cnt_q == CNT_W'(3))
                       state_d = (pre_ok_q && (DIN == pre_exp)) ? ST_LENGTH : ST_ERROR;
        ST_LENGTH:   if (bit_cnt_q == CNT_W'(LEN_W - 1)) state_d = ST_START;
        ST_START:    state_d = DIN ? ST_ERROR : ST_DATA;
        ST_DATA:     if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = ST_STOP;
        ST_STOP: begin
          if (!DIN)
            state_d = ST_ERROR;
          else if (last_stop)
            state_d = (frame_cnt_q == ADDR_W'(NUM_FRAMES - 1)) ? ST_DONE : ST_START;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge K) begin
    if (R) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      pre_ok_q    <= 1'b0;
      len_q       <= '0;
      fdata_q     <= '0;
      faddr_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b1;
    end else begin
      state_q <= state_d;
      busy_q  <= is_busy(state_d);
      done_q  <= (state_d == ST_DONE);
      err_q   <= (state_d == ST_ERROR);
      rdy_q   <= !((state_d == ST_DONE) || (state_d == ST_ERROR));
      we_q    <= 1'b0;
      if (take) begin
        if (state_d != state_q)
          bit_cnt_q <= (state_q == ST_IDLE) ? CNT_W'(1) : '0;
        else if (state_q != ST_IDLE)
          bit_cnt_q <= bit_cnt_q + 1'b1;
        if (state_q == ST_IDLE)     pre_ok_q <= 1'b1;
        if (state_q == ST_PREAMBLE) pre_ok_q <= pre_ok_q && (DIN == pre_exp);
        if (state_q == ST_LENGTH)   len_q    <= {len_q[LEN_W-2:0], DIN};
        if ((state_q == ST_STOP) && DIN && last_stop) begin
          fdata_q <= sh_par;
          faddr_q <= frame_cnt_q;
          we_q    <= 1'b1;
          if (state_d == ST_START) frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  assign DIN_READY  = rdy_q;
  assign FRAME_DATA = fdata_q;
  assign FRAME_ADDR = faddr_q;
  assign FRAME_WE   = we_q;
  assign LEN_CNT    = len_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Scoreboard bench for xc20xx_cfg_loader with 4-bit frames and 2 frames per bitstream.
module tb_xc20xx_cfg_loader;

  logic        K = 1'b0;
  logic        R = 1'b0;
  logic        DIN = 1'b0;
  logic        DIN_VALID = 1'b0;
  logic        DIN_READY;
  logic [3:0]  FRAME_DATA;
  logic [7:0]  FRAME_ADDR;
  logic        FRAME_WE;
  logic [23:0] LEN_CNT;
  logic        BUSY, DONE, ERR;

  xc20xx_cfg_loader #(.FRAME_BITS(4), .NUM_FRAMES(2), .ADDR_W(8)) dut (
    .K(K), .R(R), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .FRAME_DATA(FRAME_DATA), .FRAME_ADDR(FRAME_ADDR), .FRAME_WE(FRAME_WE),
    .LEN_CNT(LEN_CNT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 K = ~K;

  typedef struct { logic [7:0] addr; logic [3:0] data; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  bit gap      = 1'b0;
  logic took_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-write monitor: every write must follow a consuming edge and match the scoreboard head.
  always @(negedge K) begin
    if (FRAME_WE) begin
      exp_t e;
      we_cnt++;
      check_eq("we_after_take", took_prev, 1);
      if (sb.size() == 0) check_eq("we_unexpected", FRAME_WE, 0);
      else begin
        e = sb.pop_front();
        check_eq("we_addr", FRAME_ADDR, e.addr);
        check_eq("we_data", FRAME_DATA, e.data);
      end
    end
    took_prev = DIN_VALID && DIN_READY && !R;
  end

  task automatic send_bit(input logic b);
    DIN = b;
    DIN_VALID = 1'b1;
    @(posedge K); #1;
    DIN_VALID = 1'b0;
    if (gap) begin
      DIN = 1'($urandom);
      @(posedge K); #1;
    end
  endtask

  task automatic send_vec(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) send_bit(t[i]);
  endtask

  task automatic send_hdr();
    send_vec(32'hF, 4);
    send_vec(32'h2, 4);
    send_vec(32'h00002A, 24);
  endtask

  task automatic send_frame(input logic st, input logic [3:0] d, input logic [2:0] sp,
                            input logic [7:0] addr);
    exp_t e;
    send_bit(st);
    send_vec({28'b0, d}, 4);
    if (!st && sp == 3'b111) begin
      e.addr = addr;
      e.data = d;
      sb.push_back(e);
    end
    send_vec({29'b0, sp}, 3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge K); #1; end
  endtask

  task automatic do_reset();
    R = 1'b1;
    DIN_VALID = 1'b0;
    @(posedge K); #1;
    R = 1'b0;
    sb.delete();
    we_cnt = 0;
  endtask

  task automatic full_stream(input string tag);
    send_hdr();
    check_eq({tag, "_busy"}, BUSY, 1);
    send_frame(1'b0, 4'b1010, 3'b111, 8'd0);
    send_frame(1'b0, 4'b0110, 3'b111, 8'd1);
    idle(3);
    check_eq({tag, "_done"}, DONE, 1);
    check_eq({tag, "_err"}, ERR, 0);
    check_eq({tag, "_busy_end"}, BUSY, 0);
    check_eq({tag, "_len"}, LEN_CNT, 32'h2A);
    check_eq({tag, "_ready"}, DIN_READY, 0);
    check_eq({tag, "_we_cnt"}, we_cnt, 2);
    check_eq({tag, "_sb_empty"}, sb.size(), 0);
    check_eq({tag, "_last_data"}, FRAME_DATA, 4'b0110);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_data"}, FRAME_DATA, 0);
    check_eq({tag, "_addr"}, FRAME_ADDR, 0);
    check_eq({tag, "_we"}, FRAME_WE, 0);
    check_eq({tag, "_len"}, LEN_CNT, 0);
    check_eq({tag, "_flags"}, {BUSY, DONE, ERR}, 3'b000);
    check_eq({tag, "_ready"}, DIN_READY, 1);
  endtask

  initial begin
    do_reset();
    check_reset_vals("rst");

    // Clean stream, back-to-back valid bits.
    full_stream("norm");

    // Same stream with DIN_VALID low every other cycle.
    do_reset();
    gap = 1'b1;
    full_stream("gap");
    gap = 1'b0;

    // Bad preamble 0011.
    do_reset();
    send_vec(32'h3, 4);
    check_eq("pre_err", ERR, 1);
    check_eq("pre_ready", DIN_READY, 0);
    idle(2);
    check_eq("pre_we_cnt", we_cnt, 0);

    // Bad stop bits on frame 0.
    do_reset();
    send_hdr();
    send_frame(1'b0, 4'b1010, 3'b101, 8'd0);
    idle(2);
    check_eq("stop_err", ERR, 1);
    check_eq("stop_we_cnt", we_cnt, 0);
    check_eq("stop_addr", FRAME_ADDR, 0);

    // Reset during DATA of frame 1, then a complete resend.
    do_reset();
    send_hdr();
    send_frame(1'b0, 4'b1010, 3'b111, 8'd0);
    send_bit(1'b0);
    send_vec(32'h1, 2);
    check_eq("abort_busy", BUSY, 1);
    do_reset();
    check_reset_vals("abort");
    idle(2);
    check_eq("abort_we_cnt", we_cnt, 0);
    full_stream("resend");

    // Start bit 1 on frame 1.
    do_reset();
    send_hdr();
    send_frame(1'b0, 4'b0101, 3'b111, 8'd0);
    send_bit(1'b1);
    idle(3);
    check_eq("start_err", ERR, 1);
    check_eq("start_we_cnt", we_cnt, 1);
    check_eq("start_sb_empty", sb.size(), 0);
    check_eq("start_data", FRAME_DATA, 4'b0101);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
